fetch_align_ctrl: RTL

- Instruction-fetch sequencer between the PC/branch logic and the word-organised instruction memory (32-bit words, combinational read) of the RV32IMC core.
- Generates word addresses and splits the returned 16/32-bit RVC/RV32 instruction stream.
- Holds straddling halfwords across word boundaries and delivers one aligned instruction per handshake to decode.
- Handles redirects (branch/jump) and decode back-pressure.

---
 rtl/fetch_align_ctrl.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/fetch_align_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_align_ctrl
//
// Instruction-fetch sequencer for the RV32IMC core. Generates word addresses
// into a word-organised instruction memory (combinational read), splits the
// returned word stream into 16-bit (RVC) and 32-bit instructions, carries a
// straddling upper halfword across word boundaries, and presents one aligned
// instruction per valid/ready handshake to decode. Redirects flush everything
// in flight and restart at the new PC.
//
// Parameters:
//   ADDR_W    word-address width of instruction memory (index wraps mod 2^ADDR_W)
//   RESET_PC  byte PC after reset (bit 0 ignored)
//
// Ports:
//   clk, rst_n            clock (rising edge), synchronous active-low reset
//   imem_addr  [ADDR_W]   word address, combinational from internal state
//   imem_rdata [32]       word read data, valid in the same cycle
//   redirect_valid/_pc    flush and restart fetch at redirect_pc (bit 0 forced 0)
//   out_valid/out_ready   handshake to decode
//   out_instr  [32]       instruction; RVC zero-extended in [15:0]
//   out_pc     [32]       byte PC of out_instr
//   out_is_c              1 = 16-bit instruction
//
// Optional feature (macro FETCH_PERF_EN):
//   perf_instr_cnt  [32]  handshakes to decode (wraps)
//   perf_bubble_cnt [32]  cycles with no valid output and no redirect (wraps)
// ---------------------------------------------------------------------------
module fetch_align_ctrl #(
  parameter int unsigned ADDR_W   = 6,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [31:0]       out_pc,
  output logic              out_is_c
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_instr_cnt,
  output logic [31:0]       perf_bubble_cnt
`endif
);

  // FILL: pc is misaligned and the halfword it points at has not been read yet.
  typedef enum logic {FETCH, FILL} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        hold_valid_q, hold_valid_d;
  logic [15:0] hold_q, hold_d;
  logic        out_valid_d;
  logic [31:0] out_instr_d;
  logic [31:0] out_pc_d;
  logic        out_is_c_d;
  logic        adv;
  logic [ADDR_W-1:0] word_idx;

  assign word_idx = pc_q[ADDR_W+1:2];

  // Move forward only when decode can take a new instruction and no flush is
  // pending; a stalled output must stay stable.
  assign adv = !redirect_valid && (!out_valid || out_ready);

  // With the lower half of a straddling instruction already held, the word
  // that completes it is the next one (index wraps with the memory size).
  assign imem_addr = (state_q == FETCH && pc_q[1] && hold_valid_q)
                   ? word_idx + ADDR_W'(1)
                   : word_idx;

  always_comb begin
    // NOTE: every signal written here gets a default first; a path that
    // skipped one would infer a latch.
    state_d      = state_q;
    pc_d         = pc_q;
    hold_valid_d = hold_valid_q;
    hold_d       = hold_q;
    out_valid_d  = out_valid;
    out_instr_d  = out_instr;
    out_pc_d     = out_pc;
    out_is_c_d   = out_is_c;

    if (redirect_valid) begin
      // Any instruction handshaken this cycle is consumed; nothing new loads.
      pc_d         = {redirect_pc[31:1], 1'b0};
      hold_valid_d = 1'b0;
      out_valid_d  = 1'b0;
    end else if (adv) begin
      out_valid_d = 1'b0;
      case (state_q)
        FILL: begin
          // Bubble: capture the upper half that pc points at.
          hold_d       = imem_rdata[31:16];
          hold_valid_d = 1'b1;
        end
        FETCH: begin
          out_valid_d = 1'b1;
          out_pc_d    = pc_q;
          if (!pc_q[1]) begin
            if (imem_rdata[1:0] != 2'b11) begin
              out_instr_d  = {16'h0000, imem_rdata[15:0]};
              out_is_c_d   = 1'b1;
              pc_d         = pc_q + 32'd2;
              hold_d       = imem_rdata[31:16];
              hold_valid_d = 1'b1;
            end else begin
              out_instr_d  = imem_rdata;
              out_is_c_d   = 1'b0;
              pc_d         = pc_q + 32'd4;
              hold_valid_d = 1'b0;
            end
          end else begin
            // Misaligned: the held halfword is the start of this instruction.
            if (hold_q[1:0] != 2'b11) begin
              out_instr_d  = {16'h0000, hold_q};
              out_is_c_d   = 1'b1;
              pc_d         = pc_q + 32'd2;
              hold_valid_d = 1'b0;
            end else begin
              out_instr_d  = {imem_rdata[15:0], hold_q};
              out_is_c_d   = 1'b0;
              pc_d         = pc_q + 32'd4;
              hold_d       = imem_rdata[31:16];
              hold_valid_d = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end

    if (redirect_valid || adv) begin
      state_d = (pc_d[1] && !hold_valid_d) ? FILL : FETCH;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= RESET_PC[1] ? FILL : FETCH;
      pc_q         <= {RESET_PC[31:1], 1'b0};
      hold_valid_q <= 1'b0;
      hold_q       <= 16'h0000;
      out_valid    <= 1'b0;
      out_instr    <= 32'h0000_0000;
      out_pc       <= 32'h0000_0000;
      out_is_c     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      hold_valid_q <= hold_valid_d;
      hold_q       <= hold_d;
      out_valid    <= out_valid_d;
      out_instr    <= out_instr_d;
      out_pc       <= out_pc_d;
      out_is_c     <= out_is_c_d;
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_instr_cnt  <= 32'd0;
      perf_bubble_cnt <= 32'd0;
    end else begin
      if (out_valid && out_ready) begin
        perf_instr_cnt <= perf_instr_cnt + 32'd1;
      end
      if (!out_valid && !redirect_valid) begin
        perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
